pattern_gen_fsm: RTL and testbench
==================================

PATTERN_GEN_FSM -- requirements
Module: pattern_gen_fsm

Interface
REQ-001 SHALL have parameter PAT_W, default 8: pattern register width in bits.
REQ-002 SHALL have parameter LEN_W, default 4: width of pat_len.
REQ-003 SHALL have parameter CNT_W, default 4: width of rep_cnt.
REQ-004 SHALL have parameter GAP, default 2: idle cycles between repetitions; 0 allowed.
REQ-005 SHALL have port clk, input, 1: clock; all state updates on the rising edge.
REQ-006 SHALL have port rstn, input, 1: reset, asynchronous, active-low.
REQ-007 SHALL have port pat_valid, input, 1: request to start a transmission.
REQ-008 SHALL have port pat_ready, output, 1: block can accept a request.
REQ-009 SHALL have port pat_data, input, PAT_W: pattern bits.
REQ-010 SHALL have port pat_len, input, LEN_W: number of pattern bits to send.
REQ-011 SHALL have port rep_cnt, input, CNT_W: extra repetitions; total sends = rep_cnt+1.
REQ-012 SHALL have port abort, input, 1: synchronous cancel of the current transmission.
REQ-013 SHALL have port data_out, output, 1: serial bit.
REQ-014 SHALL have port data_valid, output, 1: data_out carries a pattern bit this cycle.
REQ-015 SHALL have port busy, output, 1: transmission in progress.
REQ-016 SHALL have port done, output, 1: one-cycle completion pulse.

Function
REQ-017 SHALL implement FSM states IDLE, SHIFT, GAP_ST, DONE_ST; all outputs decoded from registered state and counters only, with no combinational input-to-output path.
REQ-018 SHALL drive pat_ready=1 only in IDLE; handshake = pat_valid & pat_ready at a rising edge.
REQ-019 On handshake SHALL capture pat_data, effective length L, and rep_cnt, then enter SHIFT; first bit is valid the cycle after the handshake edge.
REQ-020 Effective length L SHALL be pat_len, clamped to PAT_W when pat_len > PAT_W, and equal to PAT_W when pat_len = 0.
REQ-021 In SHIFT SHALL assert data_valid=1 and send pat_data[L-1] down to pat_data[0], one bit per cycle, MSB first.
REQ-022 After bit 0 SHALL, if repetitions remain and GAP>0, enter GAP_ST; if repetitions remain and GAP=0, restart at bit L-1 in the next cycle with no bubble; otherwise enter DONE_ST.
REQ-023 In GAP_ST SHALL hold data_valid=0 and data_out=0 for exactly GAP cycles, then return to SHIFT at bit L-1.
REQ-024 In DONE_ST SHALL assert done=1 for exactly one cycle, then enter IDLE.
REQ-025 SHALL assert busy=1 in SHIFT, GAP_ST and DONE_ST, and busy=0 in IDLE.
REQ-026 Outside SHIFT SHALL hold data_out=0 and data_valid=0.
REQ-027 Total cycles from the handshake edge to the done cycle SHALL be (rep_cnt+1)*L + rep_cnt*GAP, with done in the following cycle.
REQ-028 abort=1 in SHIFT, GAP_ST or DONE_ST SHALL force IDLE at the next edge: data_valid=0, no done pulse, and the pattern discarded.
REQ-029 abort in IDLE SHALL be ignored; abort and pat_valid together in IDLE SHALL still complete the handshake.
REQ-030 Input changes on pat_data, pat_len or rep_cnt after the handshake SHALL NOT affect the transmission in flight.
REQ-031 The repetition counter SHALL decrement once per completed pattern and never wrap; rep_cnt = 2^CNT_W-1 SHALL yield 2^CNT_W sends.

Reset
REQ-032 While rstn=0 the block SHALL be in state IDLE with data_out=0, data_valid=0, busy=0, done=0 and pat_ready=1, and all counters cleared.
REQ-033 The block SHALL perform no capture while rstn=0.
REQ-034 rstn assertion mid-transmission SHALL immediately cancel the transmission, with no done pulse after release.
REQ-035 The first handshake SHALL be accepted at the first rising edge after rstn deasserts.

Verification
REQ-036 Test: pat_data=8'h02, pat_len=3, rep_cnt=0 -> data_out 0,1,0 with data_valid=1 for 3 cycles, then done=1 for 1 cycle, then pat_ready=1.
REQ-037 Test: pat_data=8'hA5, pat_len=0, rep_cnt=1, GAP=2 -> 1010_0101, then 2 cycles with data_valid=0, then 1010_0101, then done; 18 cycles to done.
REQ-038 Test: GAP=0, pat_data=8'h01, pat_len=2, rep_cnt=2 -> data_out 0,1,0,1,0,1 back-to-back with data_valid held high throughout.
REQ-039 Test: abort asserted on the 3rd bit of an 8-bit send -> data_valid=0 from the next cycle, no done pulse, pat_ready=1.
REQ-040 Test: rstn pulsed low mid-GAP_ST -> all outputs zero, pat_ready=1, and a new request is accepted on the first edge after release.
REQ-041 Test: pat_len=12 with PAT_W=8 -> exactly 8 bits sent; pat_data changed during SHIFT -> sent bits unchanged.

Source files
------------

// File: rtl/pattern_gen_fsm.sv
// Serial pattern generator: shifts a captured pattern out MSB first, repeating
// it rep_cnt+1 times with GAP idle cycles between repetitions, then pulses done.
module pattern_gen_fsm #(
  parameter int unsigned PAT_W = 8,
  parameter int unsigned LEN_W = 4,
  parameter int unsigned CNT_W = 4,
  parameter int unsigned GAP   = 2
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             pat_valid,
  output logic             pat_ready,
  input  logic [PAT_W-1:0] pat_data,
  input  logic [LEN_W-1:0] pat_len,
  input  logic [CNT_W-1:0] rep_cnt,
  input  logic             abort,
  output logic             data_out,
  output logic             data_valid,
  output logic             busy,
  output logic             done
);

  localparam int unsigned IDX_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;
  localparam int unsigned GAP_W = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [IDX_W-1:0] IDX_MAX  = IDX_W'(PAT_W - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP > 0) ? GAP - 1 : 0);

  typedef enum logic [1:0] {IDLE, SHIFT, GAP_ST, DONE_ST} state_t;

  state_t           state_q, state_d;
  logic [PAT_W-1:0] pat_q, pat_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] len_m1_q, len_m1_d;
  logic [CNT_W-1:0] rep_q, rep_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [IDX_W-1:0] len_m1_c;
  logic             go_idle;

  // Effective length minus one: zero or oversize lengths mean the full register.
  always_comb begin
    if (pat_len == '0 || 32'(pat_len) > PAT_W) begin
      len_m1_c = IDX_MAX;
    end else begin
      len_m1_c = IDX_W'(32'(pat_len) - 32'd1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= IDLE;
      pat_q    <= '0;
      idx_q    <= '0;
      len_m1_q <= '0;
      rep_q    <= '0;
      gap_q    <= '0;
    end else begin
      state_q  <= state_d;
      pat_q    <= pat_d;
      idx_q    <= idx_d;
      len_m1_q <= len_m1_d;
      rep_q    <= rep_d;
      gap_q    <= gap_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pat_d    = pat_q;
    idx_d    = idx_q;
    len_m1_d = len_m1_q;
    rep_d    = rep_q;
    gap_d    = gap_q;
    go_idle  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pat_valid) begin
          state_d  = SHIFT;
          pat_d    = pat_data;
          len_m1_d = len_m1_c;
          idx_d    = len_m1_c;
          rep_d    = rep_cnt;
          gap_d    = '0;
        end
      end
      SHIFT: begin
        if (abort) begin
          go_idle = 1'b1;
        end else if (idx_q != '0) begin
          idx_d = idx_q - IDX_W'(1);
        end else if (rep_q != '0) begin
          // Another repetition: reload the bit index, optionally via the gap.
          rep_d = rep_q - CNT_W'(1);
          idx_d = len_m1_q;
          if (GAP > 0) begin
            state_d = GAP_ST;
            gap_d   = GAP_LAST;
          end
        end else begin
          state_d = DONE_ST;
        end
      end
      GAP_ST: begin
        if (abort) begin
          go_idle = 1'b1;
        end else if (gap_q == '0) begin
          state_d = SHIFT;
        end else begin
          gap_d = gap_q - GAP_W'(1);
        end
      end
      DONE_ST: go_idle = 1'b1;
      default: go_idle = 1'b1;
    endcase
    if (go_idle) begin
      state_d  = IDLE;
      pat_d    = '0;
      idx_d    = '0;
      len_m1_d = '0;
      rep_d    = '0;
      gap_d    = '0;
    end
  end

  // Outputs depend only on flops, never directly on inputs.
  always_comb begin
    pat_ready  = 1'b0;
    busy       = 1'b1;
    data_valid = 1'b0;
    data_out   = 1'b0;
    done       = 1'b0;
    unique case (state_q)
      IDLE: begin
        pat_ready = 1'b1;
        busy      = 1'b0;
      end
      SHIFT: begin
        data_valid = 1'b1;
        data_out   = pat_q[idx_q];
      end
      DONE_ST: done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_pattern_gen_fsm.sv
// Bench for pattern_gen_fsm: two instances (GAP=2 and GAP=0) driven in parallel
// and compared every cycle against a token-list reference model.
module tb_pattern_gen_fsm;

  logic       clk;
  logic       rstn;
  logic       pat_valid;
  logic [7:0] pat_data;
  logic [3:0] pat_len;
  logic [3:0] rep_cnt;
  logic       abort;
  logic       ready_a, out_a, valid_a, busy_a, done_a;
  logic       ready_b, out_b, valid_b, busy_b, done_b;

  pattern_gen_fsm #(.PAT_W(8), .LEN_W(4), .CNT_W(4), .GAP(2)) dut_a (
    .clk(clk), .rstn(rstn), .pat_valid(pat_valid), .pat_ready(ready_a),
    .pat_data(pat_data), .pat_len(pat_len), .rep_cnt(rep_cnt), .abort(abort),
    .data_out(out_a), .data_valid(valid_a), .busy(busy_a), .done(done_a)
  );

  pattern_gen_fsm #(.PAT_W(8), .LEN_W(4), .CNT_W(4), .GAP(0)) dut_b (
    .clk(clk), .rstn(rstn), .pat_valid(pat_valid), .pat_ready(ready_b),
    .pat_data(pat_data), .pat_len(pat_len), .rep_cnt(rep_cnt), .abort(abort),
    .data_out(out_b), .data_valid(valid_b), .busy(busy_b), .done(done_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass = 0;
  int n_chk  = 0;

  // Expected per-cycle tokens {done, valid, bit}; head==tail means idle.
  logic [2:0] exp_tok [2][512];
  int head [2];
  int tail [2];

  typedef struct {
    logic [7:0] data;
    logic [3:0] len;
    logic [3:0] rep;
    logic [7:0] exp_bits;
    int         exp_len;
    int         exp_cyc;
    int         exp_cyc0;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic model_clear();
    for (int g = 0; g < 2; g++) begin
      head[g] = 0;
      tail[g] = 0;
    end
  endtask

  task automatic expand(input int g);
    int len_eff;
    int gap;
    gap = (g == 0) ? 2 : 0;
    len_eff = (pat_len == 4'd0 || pat_len > 4'd8) ? 8 : int'(pat_len);
    head[g] = 0;
    tail[g] = 0;
    for (int r = 0; r <= int'(rep_cnt); r++) begin
      for (int i = len_eff - 1; i >= 0; i--) begin
        exp_tok[g][tail[g]] = {1'b0, 1'b1, pat_data[i]};
        tail[g]++;
      end
      if (r < int'(rep_cnt)) begin
        for (int k = 0; k < gap; k++) begin
          exp_tok[g][tail[g]] = 3'b000;
          tail[g]++;
        end
      end
    end
    exp_tok[g][tail[g]] = 3'b100;
    tail[g]++;
  endtask

  task automatic model_edge();
    for (int g = 0; g < 2; g++) begin
      if (!rstn) begin
        head[g] = 0;
        tail[g] = 0;
      end else if (head[g] == tail[g]) begin
        if (pat_valid) expand(g);
      end else if (abort) begin
        head[g] = 0;
        tail[g] = 0;
      end else begin
        head[g]++;
      end
    end
  endtask

  task automatic check_outputs();
    logic [4:0] e;
    logic [4:0] a;
    logic [2:0] t;
    for (int g = 0; g < 2; g++) begin
      if (head[g] < tail[g]) begin
        t = exp_tok[g][head[g]];
        e = {1'b0, 1'b1, t[1], t[0], t[2]};
      end else begin
        e = 5'b10000;
      end
      a = (g == 0) ? {ready_a, busy_a, valid_a, out_a, done_a}
                   : {ready_b, busy_b, valid_b, out_b, done_b};
      chk((g == 0) ? "outputs_gap2 {rdy,busy,vld,out,done}" : "outputs_gap0 {rdy,busy,vld,out,done}",
          32'(a), 32'(e));
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((busy_a || busy_b) && k < 400) begin
      step();
      k++;
    end
    chk("drain_timeout", 32'(busy_a || busy_b), 32'd0);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int         cyc [2];
    bit         seen [2];
    logic [7:0] bits;
    int         nb;
    abort     = 1'b0;
    pat_valid = 1'b1;
    pat_data  = v.data;
    pat_len   = v.len;
    rep_cnt   = v.rep;
    step();
    // Disturb the inputs after the handshake; the transmission must not change.
    pat_valid = 1'b0;
    pat_data  = ~v.data;
    pat_len   = 4'($urandom);
    rep_cnt   = 4'($urandom);
    cyc[0] = 0; cyc[1] = 0; seen[0] = 1'b0; seen[1] = 1'b0;
    bits = 8'h00; nb = 0;
    for (int k = 0; k < 400 && !(seen[0] && seen[1]); k++) begin
      if (valid_a && nb < v.exp_len) begin
        bits = {bits[6:0], out_a};
        nb++;
      end
      if (!seen[0]) begin
        if (done_a) seen[0] = 1'b1;
        else cyc[0]++;
      end
      if (!seen[1]) begin
        if (done_b) seen[1] = 1'b1;
        else cyc[1]++;
      end
      step();
    end
    chk($sformatf("vec%0d_done_seen", idx), 32'({seen[0], seen[1]}), 32'b11);
    chk($sformatf("vec%0d_cycles_gap2", idx), 32'(cyc[0]), 32'(v.exp_cyc));
    chk($sformatf("vec%0d_cycles_gap0", idx), 32'(cyc[1]), 32'(v.exp_cyc0));
    chk($sformatf("vec%0d_bit_count", idx), 32'(nb), 32'(v.exp_len));
    chk($sformatf("vec%0d_bits", idx), 32'(bits), 32'(v.exp_bits));
  endtask

  initial begin
    int n_done;
    vecs[0] = '{8'h02, 4'd3,  4'd0,  8'h02, 3, 3,   3};
    vecs[1] = '{8'hA5, 4'd0,  4'd1,  8'hA5, 8, 18,  16};
    vecs[2] = '{8'h3C, 4'd12, 4'd0,  8'h3C, 8, 8,   8};
    vecs[3] = '{8'h01, 4'd2,  4'd2,  8'h01, 2, 10,  6};
    vecs[4] = '{8'hC3, 4'd8,  4'd15, 8'hC3, 8, 158, 128};
    vecs[5] = '{8'h80, 4'd1,  4'd0,  8'h00, 1, 1,   1};
    vecs[6] = '{8'h96, 4'd5,  4'd3,  8'h16, 5, 26,  20};

    model_clear();
    rstn = 1'b0; pat_valid = 1'b1; pat_data = 8'hFF; pat_len = 4'd8; rep_cnt = 4'd0; abort = 1'b0;
    #1 check_outputs();
    // No capture while in reset even with a request pending.
    step();
    step();

    // First handshake lands on the first edge after release.
    rstn = 1'b1; pat_data = 8'h80; pat_len = 4'd1;
    step();
    chk("accept_after_reset busy", 32'(busy_a), 32'd1);
    pat_valid = 1'b0;
    drain();

    for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

    // Abort on the 3rd bit of an 8-bit send.
    pat_valid = 1'b1; pat_data = 8'hFF; pat_len = 4'd8; rep_cnt = 4'd0;
    step();
    pat_valid = 1'b0;
    step();
    step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_idle {vld,rdy,done}", 32'({valid_a, ready_a, done_a}), 32'b010);
    n_done = 0;
    repeat (12) begin
      step();
      if (done_a || done_b) n_done++;
    end
    chk("abort_no_done", 32'(n_done), 32'd0);

    // Abort together with a request in IDLE still hands off.
    abort = 1'b1; pat_valid = 1'b1; pat_data = 8'h02; pat_len = 4'd3; rep_cnt = 4'd0;
    step();
    abort = 1'b0; pat_valid = 1'b0;
    chk("abort_in_idle_accept busy", 32'(busy_a), 32'd1);
    drain();

    // Reset pulse in the middle of the gap.
    pat_valid = 1'b1; pat_data = 8'hA5; pat_len = 4'd0; rep_cnt = 4'd1;
    step();
    pat_valid = 1'b0;
    repeat (8) step();
    chk("in_gap {busy,vld}", 32'({busy_a, valid_a}), 32'b10);
    #2 rstn = 1'b0;
    model_clear();
    #1 check_outputs();
    @(negedge clk);
    rstn = 1'b1; pat_valid = 1'b1; pat_data = 8'h02; pat_len = 4'd3; rep_cnt = 4'd0;
    step();
    pat_valid = 1'b0;
    chk("accept_after_gap_reset busy", 32'(busy_a), 32'd1);
    drain();

    // Randomized traffic with occasional aborts.
    for (int c = 0; c < 600; c++) begin
      pat_valid = ($urandom_range(0, 2) == 0);
      pat_data  = 8'($urandom);
      pat_len   = 4'($urandom);
      rep_cnt   = 4'($urandom_range(0, 3));
      abort     = ($urandom_range(0, 24) == 0);
      step();
    end
    pat_valid = 1'b0;
    abort     = 1'b0;
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
